// File: rtl/alu8_pkg.sv
// Shared types and constants for the 8-bit ALU.
// Opcode encodings 4'b1011..4'b1111 are reserved and not named here.
package alu8_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        AND = 4'b0010,
        OR  = 4'b0011,
        XOR = 4'b0100,
        SLL = 4'b0101,
        SRL = 4'b0110,
        SRA = 4'b0111,
        INC = 4'b1000,
        DEC = 4'b1001,
        SLT = 4'b1010
    } alu_op_e;

endpackage

// File: rtl/alu8_comb.sv
// Combinational core of the 8-bit ALU.
// Produces next result and overflow/carry flags from a, b and op.
module alu8_comb
    import alu8_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result_d,
    output logic              overflow_d,
    output logic              carry_d
);

    logic [DATA_W:0]   sum9;
    logic [DATA_W:0]   diff9;
    logic              shift_big;
    logic [2:0]        shamt;
    logic [DATA_W-1:0] sra_val;
    alu_op_e           op_e;

    assign op_e      = alu_op_e'(op);
    assign sum9      = {1'b0, a} + {1'b0, b};
    assign diff9     = {1'b0, a} - {1'b0, b};
    // b is the full 8-bit shift amount; any upper bit set means >= 8
    assign shift_big = |b[7:3];
    assign shamt     = b[2:0];
    assign sra_val   = $signed(a) >>> shamt;

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        carry_d    = 1'b0;
        case (op_e)
            ADD: begin
                result_d   = sum9[DATA_W-1:0];
                carry_d    = sum9[DATA_W];
                overflow_d = (a[7] == b[7]) && (sum9[7] != a[7]);
            end
            SUB: begin
                result_d   = diff9[DATA_W-1:0];
                carry_d    = diff9[DATA_W];
                overflow_d = (a[7] != b[7]) && (diff9[7] != a[7]);
            end
            AND: result_d = a & b;
            OR:  result_d = a | b;
            XOR: result_d = a ^ b;
            SLL: result_d = shift_big ? '0 : (a << shamt);
            SRL: result_d = shift_big ? '0 : (a >> shamt);
            SRA: result_d = shift_big ? {DATA_W{a[7]}} : sra_val;
            INC: begin
                result_d   = a + 8'd1;
                carry_d    = (a == 8'hFF);
                overflow_d = (a == 8'h7F);
            end
            DEC: begin
                result_d   = a - 8'd1;
                carry_d    = (a == 8'h00);
                overflow_d = (a == 8'h80);
            end
            SLT: result_d = {7'd0, $signed(a) < $signed(b)};
            default: begin
                result_d   = '0;
                overflow_d = 1'b0;
                carry_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu8.sv
// 8-bit ALU top: combinational core followed by one register stage.
// Result and zero/overflow/carry flags update every rising edge.
module alu8
    import alu8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              carry
);

    logic [DATA_W-1:0] result_d;
    logic              overflow_d;
    logic              carry_d;
    logic              zero_d;

    alu8_comb u_comb (
        .a          (a),
        .b          (b),
        .op         (alu_control),
        .result_d   (result_d),
        .overflow_d (overflow_d),
        .carry_d    (carry_d)
    );

    assign zero_d = (result_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            carry    <= 1'b0;
        end else begin
            result   <= result_d;
            zero     <= zero_d;
            overflow <= overflow_d;
            carry    <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: integer reference model plus literal vectors.
// Outputs are packed as {result, zero, overflow, carry} for comparison.
module tb_alu8;
    import alu8_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = 8'hFF;
    logic [7:0] b = 8'hFF;
    logic [3:0] op = 4'b0000;
    logic [7:0] result;
    logic       zero, overflow, carry;

    int checks = 0;
    int failures = 0;

    alu8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .alu_control (op),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .carry       (carry)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                          input logic [3:0] o);
        int ua, ub, sa, sb, r, t;
        bit ov, cy;
        logic [7:0] r8;
        ua = x; ub = y;
        sa = $signed(x); sb = $signed(y);
        r = 0; ov = 0; cy = 0;
        case (o)
            4'd0: begin
                r = ua + ub; cy = (r > 255);
                t = sa + sb; ov = (t > 127) || (t < -128);
            end
            4'd1: begin
                r = ua - ub; cy = (ua < ub);
                t = sa - sb; ov = (t > 127) || (t < -128);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (ub >= 8) ? 0 : (ua << ub);
            4'd6: r = (ub >= 8) ? 0 : (ua >> ub);
            4'd7: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> ub);
            4'd8: begin
                r = ua + 1; cy = (ua == 255); ov = (sa + 1 > 127);
            end
            4'd9: begin
                r = ua - 1; cy = (ua == 0); ov = (sa - 1 < -128);
            end
            4'd10: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        r8 = r[7:0];
        return {r8, r8 == 8'h00, ov, cy};
    endfunction

    task automatic check(input string name, input logic [10:0] got,
                         input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got res=%h z=%b o=%b c=%b, want res=%h z=%b o=%b c=%b",
                     name, got[10:3], got[2], got[1], got[0],
                     exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Model compare on every edge; reset expectation while rst_n is low
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            e = rst_n ? model(a, b, op) : {8'h00, 3'b100};
            #1;
            check("model", {result, zero, overflow, carry}, e);
        end
    end

    task automatic apply(input logic [7:0] ta, input logic [7:0] tb,
                         input logic [3:0] top, input logic [10:0] e,
                         input string name);
        @(negedge clk);
        a = ta; b = tb; op = top;
        @(posedge clk);
        #1;
        check(name, {result, zero, overflow, carry}, e);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hold", {result, zero, overflow, carry}, {8'h00, 3'b100});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", {result, zero, overflow, carry}, {8'hFE, 3'b001});

        apply(8'h05, 8'h0A, 4'd0,  {8'h0F, 3'b000}, "add");
        apply(8'h0A, 8'h05, 4'd1,  {8'h05, 3'b000}, "sub");
        apply(8'h7F, 8'h01, 4'd0,  {8'h80, 3'b010}, "add_ovf");
        apply(8'h00, 8'h01, 4'd1,  {8'hFF, 3'b001}, "sub_borrow");
        apply(8'hF0, 8'hCC, 4'd2,  {8'hC0, 3'b000}, "and");
        apply(8'h33, 8'h0F, 4'd3,  {8'h3F, 3'b000}, "or");
        apply(8'hAA, 8'h55, 4'd4,  {8'hFF, 3'b000}, "xor");
        apply(8'h01, 8'h03, 4'd5,  {8'h08, 3'b000}, "sll");
        apply(8'h80, 8'h04, 4'd6,  {8'h08, 3'b000}, "srl");
        apply(8'h80, 8'h04, 4'd7,  {8'hF8, 3'b000}, "sra");
        apply(8'h80, 8'h09, 4'd7,  {8'hFF, 3'b000}, "sra_big");
        apply(8'hFF, 8'h08, 4'd5,  {8'h00, 3'b100}, "sll_big");
        apply(8'hFF, 8'h00, 4'd8,  {8'h00, 3'b101}, "inc_wrap");
        apply(8'h00, 8'h00, 4'd9,  {8'hFF, 3'b001}, "dec_wrap");
        apply(8'h7F, 8'h00, 4'd8,  {8'h80, 3'b010}, "inc_ovf");
        apply(8'h80, 8'h00, 4'd9,  {8'h7F, 3'b010}, "dec_ovf");
        apply(8'h7F, 8'h80, 4'd10, {8'h00, 3'b100}, "slt_false");
        apply(8'h80, 8'h7F, 4'd10, {8'h01, 3'b000}, "slt_true");
        apply(8'hFF, 8'hFF, 4'd15, {8'h00, 3'b100}, "reserved");

        // Back-to-back sweep over all ops
        for (int k = 0; k < 4; k++) begin
            for (int o = 0; o < 11; o++) begin
                @(negedge clk);
                a = 8'($urandom); b = 8'($urandom_range(0, 9)); op = 4'(o);
            end
        end

        // Asynchronous reset in mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {result, zero, overflow, carry}, {8'h00, 3'b100});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            op = 4'($urandom_range(0, 15));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
